// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction memory and its byte-stream loader.
package imem_pkg;

    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into one word; flags word completion and
// remembers whether the final program byte has been seen.
module imem_word_packer
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = IMEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_complete,
    output logic                  last_seen
);

    localparam int BYTES = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0] idx_reg;
    logic             last_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg  <= '0;
            last_reg <= 1'b0;
        end else if (clear) begin
            idx_reg  <= '0;
            last_reg <= 1'b0;
        end else if (accept) begin
            idx_reg <= idx_reg + IDX_W'(1);
            if (byte_last)
                last_reg <= 1'b1;
        end
    end

    // One register per byte lane; unfilled lanes stay zero, which gives the padding.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    lane_reg <= 8'h00;
                else if (clear)
                    lane_reg <= 8'h00;
                else if (accept && idx_reg == IDX_W'(gi))
                    lane_reg <= byte_data;
            end

            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign word_complete = accept && (idx_reg == LAST_IDX || byte_last);
    assign last_seen     = last_reg;

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into instruction memory, one write per packed word.
// Define IMEM_LOADER_CHECKSUM_EN to accumulate a wrapping sum of written words.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = IMEM_DATA_W,
    parameter int ADDR_WIDTH = IMEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow_err,
    output logic [DATA_WIDTH-1:0] checksum
);

    loader_state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_hold_reg;
    logic [DATA_WIDTH-1:0] wr_data_hold_reg;
    logic [ADDR_WIDTH:0]   word_count_reg;
    logic                  overflow_reg;

    logic [DATA_WIDTH-1:0] word_buf;
    logic                  word_complete;
    logic                  last_seen;
    logic                  accept;
    logic                  start_load;
    logic                  in_write;

    assign in_write   = (state_reg == WRITE);
    assign start_load = start && (state_reg == IDLE || state_reg == DONE);
    assign accept     = byte_valid && byte_ready;

    // Clearing in every WRITE cycle is safe: the word is consumed that cycle and
    // the last flag only matters for the WRITE decision, already made by then.
    imem_word_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (start_load || in_write),
        .accept       (accept),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .word         (word_buf),
        .word_complete(word_complete),
        .last_seen    (last_seen)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start)         state_next = RECV;
            RECV:       if (word_complete) state_next = WRITE;
            WRITE: begin
                if (last_seen || addr_reg == '1)
                    state_next = DONE;
                else
                    state_next = RECV;
            end
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state_reg == RECV);
        wr_en      = in_write;
        busy       = (state_reg == RECV) || in_write;
        done       = (state_reg == DONE);
        wr_addr    = in_write ? addr_reg : wr_addr_hold_reg;
        wr_data    = in_write ? word_buf : wr_data_hold_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg         <= '0;
            wr_addr_hold_reg <= '0;
            wr_data_hold_reg <= '0;
            word_count_reg   <= '0;
            overflow_reg     <= 1'b0;
        end else if (start_load) begin
            addr_reg       <= '0;
            word_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else if (in_write) begin
            wr_addr_hold_reg <= addr_reg;
            wr_data_hold_reg <= word_buf;
            word_count_reg   <= word_count_reg + (ADDR_WIDTH+1)'(1);
            if (!last_seen) begin
                if (addr_reg == '1)
                    overflow_reg <= 1'b1;
                else
                    addr_reg <= addr_reg + ADDR_WIDTH'(1);
            end
        end
    end

    assign word_count   = word_count_reg;
    assign overflow_err = overflow_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            checksum_reg <= '0;
        else if (start_load)
            checksum_reg <= '0;
        else if (in_write)
            checksum_reg <= checksum_reg + word_buf;
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams, expected writes queued
// at issue time and checked by an independent write monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [6:0]  word_count;
    logic        overflow_err;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    imem_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .word_count  (word_count),
        .overflow_err(overflow_err),
        .checksum    (checksum)
    );

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    wr_t         sb_q[$];
    wr_t         sb_exp;
    logic [7:0]  stim[$];
    logic [31:0] exp_words[$];
    int          exp_bytes;
    bit          exp_ovf;
    string       test_name;
    int          gap_tab[8] = '{0, 2, 1, 3, 0, 1, 4, 2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s/%s actual=%0h required=%0h", test_name, name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s/unexpected_write actual=addr %0d data %08h required=no write",
                         test_name, wr_addr, wr_data);
            end else begin
                sb_exp = sb_q.pop_front();
                $display("write %s addr=%0d data=%08h", test_name, wr_addr, wr_data);
                check("wr_addr", 64'(wr_addr), 64'(sb_exp.addr));
                check("wr_data", 64'(wr_data), 64'(sb_exp.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers one byte for up to 'budget' cycles; byte_ready is stable between edges.
    task automatic send_byte(input logic [7:0] d, input bit l, input int budget, output bit acc);
        bit r;
        acc        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        for (int c = 0; c < budget; c++) begin
            r = byte_ready;
            tick();
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic check_all_zero();
        check("byte_ready_rst", 64'(byte_ready), 64'(0));
        check("wr_en_rst", 64'(wr_en), 64'(0));
        check("wr_addr_rst", 64'(wr_addr), 64'(0));
        check("wr_data_rst", 64'(wr_data), 64'(0));
        check("busy_rst", 64'(busy), 64'(0));
        check("done_rst", 64'(done), 64'(0));
        check("word_count_rst", 64'(word_count), 64'(0));
        check("overflow_rst", 64'(overflow_err), 64'(0));
        check("checksum_rst", 64'(checksum), 64'(0));
    endtask

    // Queues exp_words, starts a load, streams stim and checks the final status.
    task automatic run_load(input bit with_last, input bit gaps, input bit mid_start);
        logic [31:0] sum = 32'h0;
        bit          acc;
        bit          seen_done = 1'b0;
        int          n = stim.size();
        for (int w = 0; w < exp_words.size(); w++) begin
            sb_q.push_back('{addr: 6'(w), data: exp_words[w]});
            sum += exp_words[w];
        end
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (gaps)
                repeat (gap_tab[i % 8]) tick();
            if (mid_start && i == 2)
                pulse_start();
            send_byte(stim[i], with_last && (i == n - 1), (i < exp_bytes) ? 20 : 6, acc);
            check($sformatf("byte_accepted[%0d]", i), 64'(acc), 64'(i < exp_bytes));
        end
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            tick();
        end
        check("done", 64'(seen_done), 64'(1));
        check("busy", 64'(busy), 64'(0));
        check("byte_ready", 64'(byte_ready), 64'(0));
        check("word_count", 64'(word_count), 64'(exp_words.size()));
        check("overflow_err", 64'(overflow_err), 64'(exp_ovf));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(sum));
`else
        check("checksum", 64'(checksum), 64'(0));
`endif
        check("pending_writes", 64'(sb_q.size()), 64'(0));
        sb_q.delete();
    endtask

    initial begin
        bit acc;
        test_name  = "reset";
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        repeat (2) tick();
        check_all_zero();
        reset = 1'b0;
        tick();

        test_name = "one_word";
        stim      = '{8'h13, 8'h00, 8'h50, 8'h00};
        exp_words = '{32'h00500013};
        exp_bytes = 4;
        exp_ovf   = 1'b0;
        run_load(1'b1, 1'b0, 1'b0);

        test_name = "two_words";
        stim      = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_words = '{32'h04030201, 32'h08070605};
        exp_bytes = 8;
        run_load(1'b1, 1'b0, 1'b0);

        test_name = "padded";
        stim      = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        exp_words = '{32'hDDCCBBAA, 32'h0000FFEE};
        exp_bytes = 6;
        run_load(1'b1, 1'b0, 1'b0);

        test_name = "overflow";
        stim.delete();
        exp_words.delete();
        for (int k = 0; k < 260; k++)
            stim.push_back(k[7:0]);
        for (int w = 0; w < 64; w++)
            exp_words.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        exp_bytes = 256;
        exp_ovf   = 1'b1;
        run_load(1'b0, 1'b0, 1'b0);

        test_name = "gaps_start";
        stim      = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_words = '{32'h04030201, 32'h08070605};
        exp_bytes = 8;
        exp_ovf   = 1'b0;
        run_load(1'b1, 1'b1, 1'b1);

        test_name = "reset_mid";
        pulse_start();
        send_byte(8'h5A, 1'b0, 20, acc);
        check("byte0_accepted", 64'(acc), 64'(1));
        send_byte(8'hA5, 1'b0, 20, acc);
        check("byte1_accepted", 64'(acc), 64'(1));
        reset = 1'b1;
        #1;
        check_all_zero();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero();

        test_name = "after_reset";
        stim      = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_words = '{32'h44332211};
        exp_bytes = 4;
        run_load(1'b1, 1'b0, 1'b0);

        test_name = "checksum_wrap";
        stim      = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'hB0, 8'hFF};
        exp_words = '{32'h00500013, 32'hFFB00000};
        exp_bytes = 8;
        run_load(1'b1, 1'b0, 1'b0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory read port (6-bit word address, 32-bit data, 64 words).
- Receives a program as a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Issues one write per word at incrementing addresses from 0.
- Sits between the boot/debug byte source and the instruction memory write port; the CPU is held off until done.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- ADDR_WIDTH, 6, word address width; depth = 2**ADDR_WIDTH = 64.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- byte_valid  in  1  byte_data/byte_last valid.
- byte_data  in  8  program byte.
- byte_last  in  1  marks final byte of program.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  ADDR_WIDTH  word address.
- wr_data  out  DATA_WIDTH  packed word.
- busy  out  1  high in RECV/WRITE.
- done  out  1  load finished; held until next start.
- word_count  out  ADDR_WIDTH+1  words written this load (0..64).
- overflow_err  out  1  memory filled before byte_last.
- checksum  out  DATA_WIDTH  see Optional Feature.

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0, including byte_ready, wr_en, wr_addr, wr_data, done, busy, word_count, overflow_err and checksum. Packing buffer, byte index and last flag are cleared.
- Byte transfer occurs when byte_valid && byte_ready on a rising edge.
- State machine:
  - IDLE: byte_ready=0. start=1 → RECV. On entry to RECV: address=0, byte index=0, buffer=0, word_count=0, overflow_err=0, done=0.
  - RECV: byte_ready=1, busy=1. Each transfer writes the byte into buffer[8*idx+7 : 8*idx] and increments idx. If idx==3 or byte_last=1 at transfer → WRITE; the last flag is latched. Unfilled upper bytes stay 0 (zero padding).
  - WRITE: exactly one cycle. wr_en=1, byte_ready=0, wr_addr=address, wr_data=buffer; word_count increments.
    - Latched last → DONE.
    - Else if address==63 → overflow_err=1, DONE.
    - Else address+1, buffer=0, idx=0 → RECV.
  - DONE: done=1, busy=0, byte_ready=0. start=1 → RECV with the same clears as from IDLE.
- Latency: wr_en asserts the cycle after the word-completing transfer. Maximum throughput is 4 bytes per 5 cycles.
- wr_addr/wr_data hold their last values outside WRITE; consumers qualify with wr_en.
- start during RECV/WRITE is ignored.
- byte_last on the 4th byte produces one full word with no extra padded word.
- byte_valid gaps are allowed; the result is independent of gap pattern.
- Bytes offered in IDLE/DONE are not accepted.
- Reset mid-load aborts with no further wr_en. A partial word is discarded.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined: checksum is a DATA_WIDTH-bit wrapping sum of every wr_data written this load. It updates in the WRITE cycle, is visible from the next cycle, is cleared on start and reset, and is held through DONE.
- Undefined: checksum tied to 0, no adder synthesized; port still present.

Decomposition:
- Package imem_pkg: IMEM_ADDR_W=6, IMEM_DATA_W=32, IMEM_DEPTH=64, and enum loader_state_t {IDLE, RECV, WRITE, DONE}.
- Sub-module imem_word_packer: byte index counter, little-endian buffer, word-complete/last flags, and clear input.

Test Plan:
- Reset, start, bytes 13 00 50 00 (last on 4th) → single wr_en, wr_addr=0, wr_data=0x00500013. Then done=1, word_count=1, overflow_err=0.
- 8 bytes 01..08, last on 8th → writes addr0=0x04030201, addr1=0x08070605; done=1, word_count=2.
- 6 bytes AA BB CC DD EE FF, last on 6th → addr0=0xDDCCBBAA, addr1=0x0000FFEE (zero padded); word_count=2.
- 260 bytes, no byte_last → 64 writes addr 0..63, then overflow_err=1, done=1. byte_ready stays 0, so the final 4 bytes are refused.
- Random byte_valid gaps plus start pulsed mid-RECV → writes identical to the gap-free run, start ignored. Reset after 2 bytes → no wr_en, all outputs 0. New start plus 4 bytes → write at addr 0.
- With IMEM_LOADER_CHECKSUM_EN, words 0x00500013 and 0xFFB00000 → checksum=0x00000013 (wrap). Without the macro → checksum=0 throughout.
